// File: rtl/phase_capture.sv
// Measures the delay from a reference rise to an echo rise in clk cycles,
// averages 2^AVG_LOG2 samples and abandons measurements after MAX_DELAY cycles.
module phase_capture #(
  parameter int unsigned MAX_DELAY = 3500,
  parameter int unsigned AVG_LOG2  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        ref_in,
  input  logic        echo_in,
  output logic [11:0] delay,
  output logic        delay_valid,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
  localparam int unsigned SC_W  = AVG_LOG2 + 1;
  localparam int unsigned NSAMP = 1 << AVG_LOG2;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ACC_W-1:0]   acc, acc_n, sum;
  logic [SC_W-1:0]    scount, scount_n;
  logic [11:0]        delay_n;
  logic               delay_valid_n, timeout_n;
  logic               rec;
  logic [CNT_W-1:0]   sample;

  logic               ref_s1, ref_s2, ref_d;
  logic               echo_s1, echo_s2, echo_d;
  logic [2:0]         warm;
  logic               ref_rise, echo_rise;

  // Input synchronizers, edge-detect history and post-reset warm-up tracker
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_s1  <= 1'b0;
      ref_s2  <= 1'b0;
      ref_d   <= 1'b0;
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_d  <= 1'b0;
      warm    <= 3'b000;
    end else begin
      ref_s1  <= ref_in;
      ref_s2  <= ref_s1;
      ref_d   <= ref_s2;
      echo_s1 <= echo_in;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
      warm    <= {warm[1:0], 1'b1};
    end
  end

  // A rise only counts once the history flop holds a genuinely sampled value,
  // so a pin already high across reset never looks like a fresh rise
  assign ref_rise  = warm[2] & ref_s2 & ~ref_d;
  assign echo_rise = warm[2] & echo_s2 & ~echo_d;

  // Next-state, counter, sample recording and averaging logic
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    rec           = 1'b0;
    sample        = '0;
    timeout_n     = 1'b0;
    acc_n         = acc;
    scount_n      = scount;
    delay_n       = delay;
    delay_valid_n = 1'b0;
    sum           = '0;

    if (!enable) begin
      state_n  = IDLE;
      cnt_n    = '0;
      acc_n    = '0;
      scount_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (ref_rise && echo_rise) begin
            rec    = 1'b1;
            sample = '0;
          end else if (ref_rise) begin
            state_n = MEASURE;
            cnt_n   = CNT_W'(1);
          end
        end
        MEASURE: begin
          if (echo_rise) begin
            rec     = 1'b1;
            sample  = cnt;
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt == CNT_W'(MAX_DELAY)) begin
            timeout_n = 1'b1;
            state_n   = IDLE;
            cnt_n     = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase

      if (rec) begin
        sum = acc + ACC_W'(sample);
        if (scount == SC_W'(NSAMP - 1)) begin
          delay_n       = 12'(sum >> AVG_LOG2);
          delay_valid_n = 1'b1;
          acc_n         = '0;
          scount_n      = '0;
        end else begin
          acc_n    = sum;
          scount_n = scount + SC_W'(1);
        end
      end
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      scount      <= '0;
      delay       <= '0;
      delay_valid <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      acc         <= acc_n;
      scount      <= scount_n;
      delay       <= delay_n;
      delay_valid <= delay_valid_n;
      timeout     <= timeout_n;
      busy        <= (state_n == MEASURE);
    end
  end

endmodule

// File: doc/phase_capture.md
PHASE_CAPTURE -- requirements
Module: phase_capture

Interface
REQ-001 Parameter MAX_DELAY, default 3500, SHALL be the timeout limit in clk cycles (1..4095).
REQ-002 Parameter AVG_LOG2, default 2, SHALL set the number of samples averaged, 2^AVG_LOG2 (0..4).
REQ-003 Port clk, input, 1: the single 50 MHz clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port enable, input, 1: measurement enable; when low, no measurement runs.
REQ-006 Port ref_in, input, 1: asynchronous reference PWM (transmitted signal).
REQ-007 Port echo_in, input, 1: asynchronous received signal from one element.
REQ-008 Port delay, output, 12: averaged ref-to-echo delay in clk cycles.
REQ-009 Port delay_valid, output, 1: one-cycle strobe marking a new delay value.
REQ-010 Port timeout, output, 1: one-cycle strobe marking an abandoned measurement.
REQ-011 Port busy, output, 1: high while the FSM is in MEASURE.

Function
REQ-012 ref_in and echo_in SHALL each pass through a 2-flop synchronizer, then a third flop for edge detection; a rise is synced value 1 with previous value 0.
REQ-013 Edge-detect latency SHALL be 3 clk cycles from a pin transition to the rise flag.
REQ-014 FSM states SHALL be IDLE and MEASURE; the reset state is IDLE.
REQ-015 IDLE: on ref rise with enable=1 -> MEASURE, cnt<=1; otherwise stay in IDLE.
REQ-016 IDLE, simultaneous ref rise and echo rise with enable=1: record sample 0 and stay in IDLE.
REQ-017 MEASURE: cnt increments by 1 each cycle, so cnt = cycles since the ref rise.
REQ-018 MEASURE, echo rise: record sample = cnt and go to IDLE the next cycle.
REQ-019 MEASURE, no echo rise and cnt == MAX_DELAY: pulse timeout for one cycle, go to IDLE, and discard the measurement (accumulator unchanged).
REQ-020 MEASURE, echo rise in the same cycle as cnt == MAX_DELAY: the echo SHALL win and the sample is recorded.
REQ-021 A ref rise during MEASURE SHALL be ignored; no restart.
REQ-022 An echo rise in IDLE without a coincident ref rise SHALL be ignored.
REQ-023 Each recorded sample SHALL be added to the accumulator, which is 12+AVG_LOG2 bits wide, and increment the sample count.
REQ-024 When the sample count reaches 2^AVG_LOG2:
- delay <= accumulator sum >> AVG_LOG2 (truncating)
- delay_valid pulses in the cycle after the final sample is recorded
- accumulator and sample count clear in the same cycle
REQ-025 delay SHALL hold its value between strobes.
REQ-026 With AVG_LOG2=0, every sample SHALL produce a delay_valid.
REQ-027 enable low SHALL have the following effect:
- FSM forced to IDLE the next cycle, aborting MEASURE with no timeout pulse
- accumulator and sample count cleared
- delay held
REQ-028 delay_valid and timeout SHALL never assert in the same cycle.
REQ-029 busy SHALL be a registered decode of state == MEASURE.

Reset
REQ-030 On rst:
- state <= IDLE
- cnt, accumulator, sample count <= 0
- delay <= 0
- delay_valid, timeout, busy <= 0
- synchronizer and edge flops <= 0
REQ-031 rst SHALL override enable and abort any measurement in progress.
REQ-032 The first cycle after reset SHALL NOT detect a rise from an input already high before reset; a rise requires an observed 0 followed by 1.

Verification
REQ-033 AVG_LOG2=0, enable=1; ref_in rises, echo_in rises 343 cycles later -> delay=343 with one delay_valid pulse; busy high for 343 cycles.
REQ-034 AVG_LOG2=2; four ref/echo pairs with delays 340, 342, 344, 347 -> a single delay_valid with delay=343; no strobe after the first three.
REQ-035 MAX_DELAY=3500; ref rise with no echo -> timeout pulse exactly 3500 cycles after the ref rise flag; delay unchanged; FSM back in IDLE.
REQ-036 ref_in and echo_in driven high on the same clk -> sample 0 (AVG_LOG2=0 gives delay=0, delay_valid=1); a second ref rise mid-MEASURE does not alter the count.
REQ-037 rst or enable deasserted at cycle 100 of MEASURE -> busy=0 next cycle, no timeout or delay_valid, accumulator cleared; a subsequent pair with a 70-cycle delay (AVG_LOG2=0) yields delay=70.
